// File: rtl/network_pkg.sv
// Shared definitions for the network sequencer: default bitstream length,
// counter width derivation and the sequencer state encoding.
package network_pkg;

    localparam int WEIGHT_LENGTH_DEF = 128;

    // A counter must hold WEIGHT_LENGTH itself, hence the +1.
    function automatic int cnt_width(input int wl);
        return $clog2(wl + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/bitstream_counter.sv
// Counts ones on a single network output bitstream while sampling is enabled.
// The count saturates at WEIGHT_LENGTH so it can never wrap.
module bitstream_counter
    import network_pkg::*;
#(
    parameter int WEIGHT_LENGTH = WEIGHT_LENGTH_DEF,
    parameter int CNT_W         = cnt_width(WEIGHT_LENGTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample,
    input  logic             stream_bit,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WEIGHT_LENGTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (sample && stream_bit) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/network_sequencer.sv
// Drives one bitstream evaluation of a network: clear, WEIGHT_LENGTH enable
// cycles, drain of the network latency, then a held result handshake.
module network_sequencer
    import network_pkg::*;
#(
    parameter  int OUTPUT_SIZE   = 1,
    parameter  int WEIGHT_LENGTH = WEIGHT_LENGTH_DEF,
    parameter  int NET_LAT       = 2,
    localparam int IDX_W         = (WEIGHT_LENGTH > 1) ? $clog2(WEIGHT_LENGTH) : 1,
    localparam int CNT_W         = cnt_width(WEIGHT_LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         net_clr,
    output logic                         net_en,
    output logic [IDX_W-1:0]             bit_idx,
    input  logic [OUTPUT_SIZE-1:0]       net_bits,
    output logic [OUTPUT_SIZE*CNT_W-1:0] result,
    output logic                         result_valid,
    input  logic                         result_ready
);

    localparam int                 DRN_W      = (NET_LAT > 1) ? $clog2(NET_LAT) : 1;
    localparam logic [DRN_W-1:0]   DRAIN_LAST = DRN_W'((NET_LAT > 0) ? NET_LAT - 1 : 0);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(WEIGHT_LENGTH - 1);

    seq_state_t       state;
    logic [DRN_W-1:0] drain_cnt;
    logic             sample_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            net_clr      <= 1'b0;
            net_en       <= 1'b0;
            bit_idx      <= '0;
            result_valid <= 1'b0;
            drain_cnt    <= '0;
        end else begin
            net_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        net_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= RUN;
                    net_en  <= 1'b1;
                    bit_idx <= '0;
                end
                RUN: begin
                    if (bit_idx == IDX_LAST) begin
                        net_en    <= 1'b0;
                        bit_idx   <= '0;
                        drain_cnt <= '0;
                        // With no network latency the last sample lands this cycle.
                        if (NET_LAT == 0) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delayed copy of net_en that lines up with the network's output bits.
    if (NET_LAT == 0) begin : g_no_lat
        assign sample_en = net_en;
    end else begin : g_lat
        logic [NET_LAT-1:0] vld_p;
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= net_en;
                for (int i = 1; i < NET_LAT; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
        end
        assign sample_en = vld_p[NET_LAT-1];
    end

    for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_cnt
        bitstream_counter #(
            .WEIGHT_LENGTH(WEIGHT_LENGTH),
            .CNT_W        (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clear     (net_clr),
            .sample    (sample_en),
            .stream_bit(net_bits[g]),
            .count     (result[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench: two sequencer instances (default latency, and zero latency
// with two outputs) driven by directed evaluations.
module tb_network_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic ready_a = 1'b1, ready_b = 1'b1;

    logic        busy_a, clr_a, en_a, rv_a;
    logic [6:0]  idx_a;
    logic [0:0]  bits_a;
    logic [7:0]  res_a;

    logic        busy_b, clr_b, en_b, rv_b;
    logic [6:0]  idx_b;
    logic [1:0]  bits_b = 2'b10;
    logic [15:0] res_b;

    // 0: bits held 1, 1: bits held 0, 2: alternating bits aligned to the sample window
    int mode = 0;
    logic [1:0] net_pipe = '0;
    always @(posedge clk) net_pipe <= {net_pipe[0], en_a & ~idx_a[0]};
    assign bits_a = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : net_pipe[1];

    network_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .net_clr(clr_a),
        .net_en(en_a), .bit_idx(idx_a), .net_bits(bits_a), .result(res_a),
        .result_valid(rv_a), .result_ready(ready_a)
    );

    network_sequencer #(.OUTPUT_SIZE(2), .NET_LAT(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .net_clr(clr_b),
        .net_en(en_b), .bit_idx(idx_b), .net_bits(bits_b), .result(res_b),
        .result_valid(rv_b), .result_ready(ready_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dut;
        int res;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   t0[2];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   done_goal = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int dut, input int res, input int lat);
        exp_t e;
        e.dut = dut;
        e.res = res;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic pulse_a();
        @(negedge clk);
        start_a = 1'b1;
        t0[0] = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done();
        done_goal++;
        for (int i = 0; i < 400 && done_cnt < done_goal; i++) @(negedge clk);
        chk("eval_complete", int'(done_cnt >= done_goal), 1);
    endtask

    // Monitor: samples between the falling and rising edges.
    initial begin
        int   en_cnt[2];
        bit   prev_rv[2];
        bit   post[2];
        bit   have[2];
        exp_t cur[2];
        en_cnt  = '{0, 0};
        prev_rv = '{0, 0};
        post    = '{0, 0};
        have    = '{0, 0};
        forever begin
            @(negedge clk);
            #3;
            for (int d = 0; d < 2; d++) begin
                logic rv, rr, en, clr, bz;
                int   idx, res;
                rv  = (d == 0) ? rv_a : rv_b;
                rr  = (d == 0) ? ready_a : ready_b;
                en  = (d == 0) ? en_a : en_b;
                clr = (d == 0) ? clr_a : clr_b;
                bz  = (d == 0) ? busy_a : busy_b;
                idx = (d == 0) ? int'(idx_a) : int'(idx_b);
                res = (d == 0) ? int'(res_a) : int'(res_b);
                if (rst) begin
                    en_cnt[d]  = 0;
                    prev_rv[d] = 0;
                    post[d]    = 0;
                    have[d]    = 0;
                end else begin
                    if (post[d]) begin
                        chk("idle_busy_after_accept", int'(bz), 0);
                        chk("valid_drop_after_accept", int'(rv), 0);
                        post[d] = 0;
                    end
                    if (en) begin
                        chk("bit_idx_order", idx, en_cnt[d]);
                        en_cnt[d]++;
                    end else begin
                        chk("bit_idx_zero_outside_run", idx, 0);
                    end
                    if (clr) chk("net_clr_cycle", cyc - t0[d], 1);
                    if (rv && !prev_rv[d]) begin
                        if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result_valid dut%0d: got valid with result %0d, expected none", d, res);
                        end else begin
                            cur[d]  = exp_q.pop_front();
                            have[d] = 1;
                            chk("result_valid_latency", cyc - t0[d], cur[d].lat);
                            chk("net_en_cycle_count", en_cnt[d], 128);
                        end
                        en_cnt[d] = 0;
                    end
                    if (rv && have[d]) chk("result_value", res, cur[d].res);
                    if (rv && rr) begin
                        post[d] = 1;
                        have[d] = 0;
                        done_cnt++;
                    end
                    prev_rv[d] = rv;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_net_clr", int'(clr_a), 0);
        chk("rst_net_en", int'(en_a), 0);
        chk("rst_bit_idx", int'(idx_a), 0);
        chk("rst_result", int'(res_a), 0);
        chk("rst_result_valid", int'(rv_a), 0);
        chk("rst_b_result", int'(res_b), 0);
        chk("rst_b_busy", int'(busy_b), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All ones, then zeros, then alternating
        mode = 0; push_exp(0, 128, 132); pulse_a(); wait_done();
        mode = 1; push_exp(0, 0, 132);   pulse_a(); wait_done();
        chk("result_held_in_idle", int'(res_a), 0);
        mode = 2; push_exp(0, 64, 132);  pulse_a(); wait_done();

        // Extra start pulses in RUN (bit_idx 10) and DRAIN are ignored
        mode = 0;
        push_exp(0, 128, 132);
        pulse_a();
        repeat (11) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (117) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("no_queued_start", int'(busy_a), 0);

        // Consumer stalls five cycles; start during the accept cycle is ignored
        ready_a = 1'b0;
        push_exp(0, 128, 132);
        pulse_a();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rv_a) break;
        end
        for (int i = 0; i < 5; i++) begin
            chk("valid_held_while_stalled", int'(rv_a), 1);
            chk("result_held_while_stalled", int'(res_a), 128);
            @(negedge clk);
        end
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("start_at_accept_ignored", int'(busy_a), 0);

        // Reset in the middle of RUN aborts without a result
        pulse_a();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en_a && idx_a == 7'd50) break;
        end
        chk("reached_bit_idx_50", int'(idx_a), 50);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_net_en", int'(en_a), 0);
        chk("abort_bit_idx", int'(idx_a), 0);
        chk("abort_result", int'(res_a), 0);
        chk("abort_result_valid", int'(rv_a), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(0, 128, 132); pulse_a(); wait_done();

        // Zero-latency, two-output instance: DRAIN skipped
        push_exp(1, 32768, 130);
        @(negedge clk);
        start_b = 1'b1;
        t0[1] = cyc;
        @(negedge clk);
        start_b = 1'b0;
        wait_done();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
